ram_sync: RTL and testbench
===========================

# ram_sync

Parametrised synchronous single-port data RAM for the NBBPU: the successor to the fixed 16-bit `ram`. It adds configurable width and depth, byte-lane write enables, and a registered read with a valid strobe. It also adds a request/ready handshake, an out-of-range error flag, and a hardware clear sequencer that fills the array with a known value after reset. It sits between the CPU load/store path and data memory.

## Interface
- `DATA_WIDTH`, 16, word width in bits; must be a multiple of 8
- `ADDR_WIDTH`, 16, address bus width in bits (word addresses)
- `DEPTH`, 256, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH
- `CLEAR_ON_RESET`, 1, 1 = run clear sequence after reset; 0 = skip it
- `INIT_VALUE`, 0, word written to every location during clear
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `request`  in  1  transaction valid
- `write_enable`  in  1  1 = write, 0 = read; sampled with `request`
- `byte_enable`  in  DATA_WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i]
- `address`  in  ADDR_WIDTH  word address
- `write_data`  in  DATA_WIDTH  write word
- `ready`  out  1  block can accept a transaction this cycle
- `read_valid`  out  1  one-cycle pulse: `read_data` holds a new read result
- `read_data`  out  DATA_WIDTH  registered read result
- `error`  out  1  one-cycle pulse: previous accepted transaction had `address` ≥ DEPTH

## Operation
- FSM states: CLEAR, READY.
- Reset (`reset`=0 at an edge): next state is CLEAR if CLEAR_ON_RESET=1, else READY. Clear counter ← 0. `ready`, `read_valid`, `error` ← 0; `read_data` ← 0. Array contents are not touched by reset itself.
- CLEAR: each edge with `reset`=1 writes INIT_VALUE (all bytes) to address `counter`, then increments `counter`. After the write to DEPTH-1 → READY. `request` is ignored; `ready`=0 throughout.
- READY: `ready`=1. A transaction is accepted on an edge where `request`=1 and `ready`=1.
- Accepted write, in range: for each i with `byte_enable[i]`=1, byte i ← `write_data` byte i; other bytes unchanged. `byte_enable`=0 writes nothing and is not an error. No `read_valid` pulse; `read_data` unchanged.
- Accepted read, in range: `read_data` ← mem[`address`]; `read_valid`=1 for exactly one cycle.
- Out of range (`address` ≥ DEPTH): writes are dropped. Reads set `read_data` ← 0 with `read_valid`=1. `error`=1 for one cycle in both cases.
- `read_data` holds its value until the next accepted read or reset.
- Reset asserted mid-CLEAR restarts the clear from address 0. Reset asserted in READY discards any transaction presented on that edge.
- Single port: one transaction per cycle. Back-to-back transactions are accepted every cycle.

## Timing
- Clear duration: with CLEAR_ON_RESET=1, `ready` rises after exactly DEPTH rising edges with `reset`=1. With CLEAR_ON_RESET=0, it rises after the first such edge.
- Read latency: read accepted at edge N → `read_data`/`read_valid` valid after edge N, deasserted after edge N+1 unless another read is accepted at N+1.
- Write takes effect at the accepting edge. A read accepted at the next edge returns the new data (read-after-write, no stall).
- `error` is asserted after the accepting edge N and cleared after edge N+1 unless re-triggered.
- All outputs are registered. There is no combinational path from inputs to outputs except none; `ready` is a function of FSM state only.

## Test plan
- Clear: DEPTH=16, CLEAR_ON_RESET=1, INIT_VALUE=16'hA5A5; release reset → `ready` low for 16 edges then high; reads of addresses 0–15 each return 16'hA5A5 with a single `read_valid` pulse.
- Byte lanes: write 16'h1234 to address 3 with `byte_enable`=2'b11, then 16'hFFFF with 2'b01 → read of address 3 returns 16'h12FF; a write with 2'b00 leaves 16'h12FF.
- Back-to-back: write 16'h000F to address 1 at edge N, read address 1 at edge N+1 → `read_data`=16'h000F, `read_valid`=1 after N+1 only.
- Out of range: DEPTH=16, write to address 16, then read address 16 → `error` pulses after each; read returns 0; address 0 is unchanged.
- Reset mid-clear: DEPTH=16; assert reset after 8 clear edges, release → `ready` rises only after 16 further edges; all words equal INIT_VALUE.
- Handshake gating: hold `request`=1 during CLEAR → no writes occur, no `read_valid`; first acceptance happens on the first edge with `ready`=1.

Source files
------------

// File: rtl/ram_sync.sv
// ram_sync: parametrised single-port data RAM with byte lanes,
// registered read, range error flag and post-reset clear sequencer.
module ram_sync #(
   parameter int                    DATA_WIDTH     = 16,
   parameter int                    ADDR_WIDTH     = 16,
   parameter int                    DEPTH          = 256,
   parameter bit                    CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    request,
   input  logic                    write_enable,
   input  logic [DATA_WIDTH/8-1:0] byte_enable,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH-1:0]   write_data,
   output logic                    ready,
   output logic                    read_valid,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    error
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR,
      S_READY
   } state_t;

   localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_READY;

   state_t state;
   state_t state_nx;

   logic [CW-1:0]         counter;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  in_range;
   logic                  mem_we;
   logic [NB-1:0]         mem_be;
   logic [CW-1:0]         mem_idx;
   logic [DATA_WIDTH-1:0] mem_wd;

   assign accept   = ready & request;
   assign in_range = {1'b0, address} < DEPTH_W;

   // State register; reset restarts the clear sequence
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= RST_STATE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: leave CLEAR after the last word has been written
   always_comb begin
      state_nx = state;
      unique case (state)
         S_CLEAR: if (counter == LAST) state_nx = S_READY;
         S_READY: state_nx = S_READY;
         default: state_nx = RST_STATE;
      endcase
   end

   // Clear address counter, advances once per clear write
   always_ff @(posedge clock) begin
      if (!reset) begin
         counter <= '0;
      end else if (state == S_CLEAR) begin
         counter <= counter + 1'b1;
      end
   end

   // Array write port shared by the clear sequencer and CPU stores
   always_comb begin
      mem_we  = 1'b0;
      mem_be  = '0;
      mem_idx = address[CW-1:0];
      mem_wd  = write_data;
      if (reset) begin
         unique case (state)
            S_CLEAR: begin
               mem_we  = 1'b1;
               mem_be  = '1;
               mem_idx = counter;
               mem_wd  = INIT_VALUE;
            end
            S_READY: begin
               if (accept && write_enable && in_range) begin
                  mem_we = 1'b1;
                  mem_be = byte_enable;
               end
            end
            default: mem_we = 1'b0;
         endcase
      end
   end

   // Byte-lane masked array update; reset leaves contents alone
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) begin
               mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
            end
         end
      end
   end

   // Registered handshake, read result, valid and error strobes
   always_ff @(posedge clock) begin
      if (!reset) begin
         ready      <= 1'b0;
         read_valid <= 1'b0;
         read_data  <= '0;
         error      <= 1'b0;
      end else begin
         ready      <= (state_nx == S_READY);
         read_valid <= accept & ~write_enable;
         error      <= accept & ~in_range;
         if (accept && !write_enable) begin
            read_data <= in_range ? mem[address[CW-1:0]] : '0;
         end
      end
   end

endmodule

// File: tb/tb_ram_sync.sv
// tb_ram_sync: directed and random stimulus for ram_sync,
// checked every cycle against a word-array reference model.
module tb_ram_sync;

   localparam int          DP   = 16;
   localparam logic [15:0] INIT = 16'hA5A5;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        request = 1'b0;
   logic        write_enable = 1'b0;
   logic [1:0]  byte_enable = 2'b00;
   logic [15:0] address = 16'h0;
   logic [15:0] write_data = 16'h0;
   logic        ready;
   logic        read_valid;
   logic [15:0] read_data;
   logic        error;

   logic        request0 = 1'b0;
   logic        write_enable0 = 1'b0;
   logic [1:0]  byte_enable0 = 2'b00;
   logic [15:0] address0 = 16'h0;
   logic [15:0] write_data0 = 16'h0;
   logic        ready0;
   logic        read_valid0;
   logic [15:0] read_data0;
   logic        error0;

   int checks = 0;
   int failures = 0;

   ram_sync #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DP),
      .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
   ) dut (
      .clock(clock), .reset(reset), .request(request),
      .write_enable(write_enable), .byte_enable(byte_enable),
      .address(address), .write_data(write_data), .ready(ready),
      .read_valid(read_valid), .read_data(read_data), .error(error)
   );

   ram_sync #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(DP),
      .CLEAR_ON_RESET(1'b0), .INIT_VALUE(16'h0)
   ) dut0 (
      .clock(clock), .reset(reset), .request(request0),
      .write_enable(write_enable0), .byte_enable(byte_enable0),
      .address(address0), .write_data(write_data0), .ready(ready0),
      .read_valid(read_valid0), .read_data(read_data0), .error(error0)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: word array plus edge count since reset
   logic [15:0] mdl [DP];
   int          cnt = 0;
   bit          started = 0;
   bit          acc;
   bit          oor;
   logic        e_ready, e_rv, e_err, e_ready0;
   logic [15:0] e_rd;

   always @(posedge clock) begin
      if (!reset) begin
         started  = 1;
         cnt      = 0;
         e_ready  = 0;
         e_rv     = 0;
         e_err    = 0;
         e_rd     = 16'h0;
         e_ready0 = 0;
      end else if (started) begin
         acc   = e_ready && request;
         e_rv  = 0;
         e_err = 0;
         if (acc) begin
            oor   = int'(address) >= DP;
            e_err = oor;
            if (write_enable) begin
               if (!oor) begin
                  for (int b = 0; b < 2; b++)
                     if (byte_enable[b])
                        mdl[address[3:0]][8*b +: 8] = write_data[8*b +: 8];
               end
            end else begin
               e_rv = 1;
               e_rd = oor ? 16'h0 : mdl[address[3:0]];
            end
         end
         if (cnt < DP) cnt++;
         if (cnt == DP && !e_ready) begin
            for (int k = 0; k < DP; k++) mdl[k] = INIT;
            e_ready = 1;
         end
         e_ready0 = 1;
      end
   end

   // Compare every cycle mid-period
   always @(negedge clock) begin
      if (started) begin
         chk("ready", ready, e_ready);
         chk("read_valid", read_valid, e_rv);
         chk("error", error, e_err);
         chk("read_data", read_data, e_rd);
         chk("nc_ready", ready0, e_ready0);
         chk("nc_idle", {read_valid0, error0, read_data0}, 0);
      end
   end

   task automatic cyc(input bit rq, input bit we, input logic [1:0] be,
                      input logic [15:0] a, input logic [15:0] wd);
      request      = rq;
      write_enable = we;
      byte_enable  = be;
      address      = a;
      write_data   = wd;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) cyc(0, 0, 2'b00, 16'h0, 16'h0);
      chk("rst_ready", ready, 0);
      chk("rst_rdata", read_data, 0);
      chk("rst_rvalid", read_valid, 0);

      // clear with request held high: no acceptance until ready
      reset = 1'b1;
      for (int i = 0; i < DP; i++) begin
         cyc(1, 0, 2'b00, 16'd5, 16'h0);
         chk("clr_ready", ready, (i == DP - 1));
         chk("clr_rvalid", read_valid, 0);
         if (i == 0) chk("nc_first", ready0, 1);
      end
      cyc(1, 0, 2'b00, 16'd5, 16'h0);
      chk("gate_rvalid", read_valid, 1);
      chk("gate_rdata", read_data, 16'hA5A5);

      for (int a = 0; a < DP; a++) begin
         cyc(1, 0, 2'b00, 16'(a), 16'h0);
         chk("clr_word", read_data, 16'hA5A5);
      end

      // byte lanes
      cyc(1, 1, 2'b11, 16'd3, 16'h1234);
      cyc(1, 1, 2'b01, 16'd3, 16'hFFFF);
      cyc(1, 0, 2'b00, 16'd3, 16'h0);
      chk("lane_rd", read_data, 16'h12FF);
      cyc(1, 1, 2'b00, 16'd3, 16'h0000);
      chk("lane_be0_err", error, 0);
      cyc(1, 0, 2'b00, 16'd3, 16'h0);
      chk("lane_be0", read_data, 16'h12FF);

      // read after write, back to back
      cyc(1, 1, 2'b11, 16'd1, 16'h000F);
      chk("b2b_wr_rv", read_valid, 0);
      cyc(1, 0, 2'b00, 16'd1, 16'h0);
      chk("b2b_rd", read_data, 16'h000F);
      chk("b2b_rv", read_valid, 1);
      cyc(0, 0, 2'b00, 16'd0, 16'h0);
      chk("b2b_rv_drop", read_valid, 0);
      chk("b2b_hold", read_data, 16'h000F);

      // out of range
      cyc(1, 1, 2'b11, 16'd16, 16'hBEEF);
      chk("oor_wr_err", error, 1);
      chk("oor_wr_rv", read_valid, 0);
      cyc(0, 0, 2'b00, 16'd0, 16'h0);
      chk("oor_err_drop", error, 0);
      cyc(1, 0, 2'b00, 16'd16, 16'h0);
      chk("oor_rd_err", error, 1);
      chk("oor_rd_rv", read_valid, 1);
      chk("oor_rd", read_data, 16'h0);
      cyc(1, 0, 2'b00, 16'hFFFF, 16'h0);
      chk("oor_top_err", error, 1);
      cyc(1, 0, 2'b00, 16'd0, 16'h0);
      chk("oor_addr0", read_data, 16'hA5A5);
      chk("oor_addr0_err", error, 0);

      // random traffic
      repeat (400) begin
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 16'($urandom_range(0, 19)),
             16'($urandom));
      end

      // reset in the middle of a clear
      reset = 1'b0;
      cyc(0, 0, 2'b00, 16'd0, 16'h0);
      reset = 1'b1;
      repeat (8) cyc(1, 1, 2'b11, 16'd2, 16'h5555);
      reset = 1'b0;
      cyc(1, 1, 2'b11, 16'd2, 16'h5555);
      chk("mid_rst_ready", ready, 0);
      reset = 1'b1;
      for (int i = 0; i < DP; i++) begin
         cyc(0, 0, 2'b00, 16'd0, 16'h0);
         chk("mid_ready", ready, (i == DP - 1));
      end
      for (int a = 0; a < DP; a++) begin
         cyc(1, 0, 2'b00, 16'(a), 16'h0);
         chk("mid_word", read_data, 16'hA5A5);
      end
      repeat (3) cyc(0, 0, 2'b00, 16'd0, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
